// File: rtl/pll_phase_pkg.sv
// Shared types and helpers for the PLL dynamic phase-step sequencer.
// The absolute-target mode is enabled with the PLL_PHASE_STEP_ABS_EN macro.
package pll_phase_pkg;

  localparam int PHASE_W_DEF = 8;

  typedef logic [PHASE_W_DEF-1:0] phase_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_SETUP,
    ST_ROT_H,
    ST_ROT_L,
    ST_LOAD,
    ST_SETTLE
  } state_e;

  // One phase step with wrap at the output period; pos is always < period.
  function automatic int unsigned wrap_step(input int unsigned pos,
                                            input logic        dir,
                                            input int unsigned period);
    if (dir) begin
      return (pos + 1 >= period) ? 0 : pos + 1;
    end
    return (pos == 0) ? period - 1 : pos - 1;
  endfunction

endpackage

// File: rtl/pll_phase_pos_tracker.sv
// Per-output phase position registers with modulo-period wrap.
// With PLL_PHASE_STEP_ABS_EN it also derives the shortest path to a target.
module pll_phase_pos_tracker
  import pll_phase_pkg::*;
#(
  parameter int NUM_OUT      = 4,
  parameter int PHASE_W      = 8,
  parameter int PERIOD_STEPS = 32,
  parameter int CH_W         = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       upd_i,
  input  logic [CH_W-1:0]            ch_i,
  input  logic                       dir_i,
`ifdef PLL_PHASE_STEP_ABS_EN
  input  logic [PHASE_W-1:0]         target_i,
  output logic                       abs_dir_o,
  output logic [PHASE_W-1:0]         abs_steps_o,
`endif
  output logic [NUM_OUT*PHASE_W-1:0] pos_o
);

  logic [PHASE_W-1:0] pos_q [NUM_OUT];

  // NOTE: the position array is small and must read zero after an async reset,
  // so it is reset like any other register rather than left as uninitialised RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OUT; i++) pos_q[i] <= '0;
    end else if (upd_i) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (ch_i == CH_W'(i)) begin
          pos_q[i] <= PHASE_W'(wrap_step(32'(pos_q[i]), dir_i, PERIOD_STEPS));
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_pos
    assign pos_o[g*PHASE_W +: PHASE_W] = pos_q[g];
  end

`ifdef PLL_PHASE_STEP_ABS_EN
  logic [PHASE_W-1:0] cur_pos;
  int                 cur_v;
  int                 tgt_v;
  int                 dist;

  always_comb begin
    cur_pos = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (ch_i == CH_W'(i)) cur_pos = pos_q[i];
    end
  end

  // Forward distance modulo the period; a tie at half a period advances.
  always_comb begin
    cur_v = int'(cur_pos);
    tgt_v = int'(target_i);
    dist  = (tgt_v >= cur_v) ? (tgt_v - cur_v) : (tgt_v + PERIOD_STEPS - cur_v);
    if (dist <= PERIOD_STEPS / 2) begin
      abs_dir_o   = 1'b1;
      abs_steps_o = PHASE_W'(dist);
    end else begin
      abs_dir_o   = 1'b0;
      abs_steps_o = PHASE_W'(PERIOD_STEPS - dist);
    end
  end
`endif

endmodule

// File: rtl/pll_phase_step_ctrl.sv
// Sequencer for a fabric PLL dynamic phase-adjust port (select, direction, rotate, load).
// Optional absolute-target requests are enabled with the PLL_PHASE_STEP_ABS_EN macro.
module pll_phase_step_ctrl
  import pll_phase_pkg::*;
#(
  parameter int  NUM_OUT       = 4,
  parameter int  PHASE_W       = 8,
  parameter int  PERIOD_STEPS  = 32,
  parameter int  ROT_HI        = 2,
  parameter int  ROT_LO        = 2,
  parameter int  LOAD_CYCLES   = 1,
  parameter int  SETTLE_CYCLES = 16,
  localparam int CH_W          = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       PLL_LOCK,
  input  logic                       REQ_VALID,
  output logic                       REQ_READY,
  input  logic [CH_W-1:0]            REQ_CH,
  input  logic                       REQ_DIR,
  input  logic [PHASE_W-1:0]         REQ_STEPS,
`ifdef PLL_PHASE_STEP_ABS_EN
  input  logic                       REQ_ABS,
`endif
  output logic [NUM_OUT-1:0]         PHASE_OUT_SEL,
  output logic                       PHASE_DIRECTION,
  output logic                       PHASE_ROTATE,
  output logic                       LOAD_PHASE_N,
  output logic                       BUSY,
  output logic                       DONE,
  output logic                       ERR,
  output logic [NUM_OUT*PHASE_W-1:0] PHASE_POS
);

  localparam int CNT_W = 16;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PHASE_W-1:0] steps_q, steps_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic               dir_q, dir_d;
  logic               err_q, err_d;
  logic               done_q, done_d;
  logic [NUM_OUT-1:0] sel_q;
  logic               pdir_q;
  logic               rot_q;
  logic               load_n_q;
  logic               pos_upd;
  logic               accept;
  logic               ch_ok;
  logic               active_d;
  logic               last_hi, last_lo, last_load, last_settle;

`ifdef PLL_PHASE_STEP_ABS_EN
  logic               abs_dir;
  logic [PHASE_W-1:0] abs_steps;
  logic               tgt_ok;

  assign tgt_ok = int'(REQ_STEPS) < PERIOD_STEPS;
`endif

  assign REQ_READY   = (state_q == ST_IDLE) && PLL_LOCK;
  assign accept      = REQ_VALID && REQ_READY;
  assign ch_ok       = int'(REQ_CH) < NUM_OUT;
  assign last_hi     = (cnt_q == CNT_W'(ROT_HI - 1));
  assign last_lo     = (cnt_q == CNT_W'(ROT_LO - 1));
  assign last_load   = (cnt_q == CNT_W'(LOAD_CYCLES - 1));
  assign last_settle = (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    steps_d = steps_q;
    ch_d    = ch_q;
    dir_d   = dir_q;
    err_d   = err_q;
    done_d  = 1'b0;
    pos_upd = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          err_d   = 1'b0;
          ch_d    = REQ_CH;
          dir_d   = REQ_DIR;
          steps_d = REQ_STEPS;
          if (!ch_ok) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end
`ifdef PLL_PHASE_STEP_ABS_EN
          else if (REQ_ABS && !tgt_ok) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (REQ_ABS) begin
            state_d = ST_CALC;
          end
`endif
          else begin
            state_d = ST_SETUP;
          end
        end
      end
`ifdef PLL_PHASE_STEP_ABS_EN
      ST_CALC: begin
        dir_d   = abs_dir;
        steps_d = abs_steps;
        state_d = ST_SETUP;
      end
`endif
      ST_SETUP: state_d = (steps_q == '0) ? ST_LOAD : ST_ROT_H;
      ST_ROT_H: begin
        // A step counts only once its high phase has completed.
        if (last_hi) begin
          state_d = ST_ROT_L;
          steps_d = steps_q - PHASE_W'(1);
          pos_upd = 1'b1;
        end
      end
      ST_ROT_L: begin
        if (last_lo) state_d = (steps_q != '0) ? ST_ROT_H : ST_LOAD;
      end
      ST_LOAD: begin
        if (last_load) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (last_settle) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Losing lock aborts any sequence; partial progress stays in the positions.
    if (state_q != ST_IDLE && !PLL_LOCK) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
      err_d   = 1'b1;
      pos_upd = 1'b0;
    end

    cnt_d    = (state_d != state_q || state_q == ST_IDLE) ? '0 : cnt_q + CNT_W'(1);
    active_d = (state_d == ST_SETUP) || (state_d == ST_ROT_H) ||
               (state_d == ST_ROT_L) || (state_d == ST_LOAD);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      steps_q  <= '0;
      ch_q     <= '0;
      dir_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      sel_q    <= '0;
      pdir_q   <= 1'b0;
      rot_q    <= 1'b0;
      load_n_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      steps_q  <= steps_d;
      ch_q     <= ch_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      done_q   <= done_d;
      // PLL-facing pins are registered from the next state to keep them glitch-free.
      sel_q    <= active_d ? (NUM_OUT'(1) << ch_d) : '0;
      pdir_q   <= active_d && dir_d;
      rot_q    <= (state_d == ST_ROT_H);
      load_n_q <= (state_d != ST_LOAD);
    end
  end

  pll_phase_pos_tracker #(
    .NUM_OUT      (NUM_OUT),
    .PHASE_W      (PHASE_W),
    .PERIOD_STEPS (PERIOD_STEPS),
    .CH_W         (CH_W)
  ) u_pos (
    .clk         (CLK),
    .rst_n       (RESET_N),
    .upd_i       (pos_upd),
    .ch_i        (ch_q),
    .dir_i       (dir_q),
`ifdef PLL_PHASE_STEP_ABS_EN
    .target_i    (steps_q),
    .abs_dir_o   (abs_dir),
    .abs_steps_o (abs_steps),
`endif
    .pos_o       (PHASE_POS)
  );

  assign PHASE_OUT_SEL   = sel_q;
  assign PHASE_DIRECTION = pdir_q;
  assign PHASE_ROTATE    = rot_q;
  assign LOAD_PHASE_N    = load_n_q;
  assign BUSY            = (state_q != ST_IDLE);
  assign DONE            = done_q;
  assign ERR             = err_q;

endmodule

// File: tb/tb_pll_phase_step_ctrl.sv
// Scoreboard bench for pll_phase_step_ctrl with three outputs so that
// channel index 3 is representable and out of range.
module tb_pll_phase_step_ctrl;

  localparam int NO = 3;

  typedef struct {
    int          lat;
    logic        err;
    logic        dir;
    logic [2:0]  sel_oh;
    logic [63:0] mask;
    int          load;
    int          sel;
    logic [23:0] pos;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        PLL_LOCK;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [1:0]  REQ_CH;
  logic        REQ_DIR;
  logic [7:0]  REQ_STEPS;
`ifdef PLL_PHASE_STEP_ABS_EN
  logic        REQ_ABS;
`endif
  logic [2:0]  PHASE_OUT_SEL;
  logic        PHASE_DIRECTION;
  logic        PHASE_ROTATE;
  logic        LOAD_PHASE_N;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic [23:0] PHASE_POS;

  int   checks    = 0;
  int   failures  = 0;
  int   n_issued  = 0;
  int   n_done    = 0;
  int   cyc       = 0;
  exp_t exp_q [$];
  logic [7:0] exp_pos [NO];

  pll_phase_step_ctrl #(
    .NUM_OUT (NO)
  ) dut (
    .CLK             (CLK),
    .RESET_N         (RESET_N),
    .PLL_LOCK        (PLL_LOCK),
    .REQ_VALID       (REQ_VALID),
    .REQ_READY       (REQ_READY),
    .REQ_CH          (REQ_CH),
    .REQ_DIR         (REQ_DIR),
    .REQ_STEPS       (REQ_STEPS),
`ifdef PLL_PHASE_STEP_ABS_EN
    .REQ_ABS         (REQ_ABS),
`endif
    .PHASE_OUT_SEL   (PHASE_OUT_SEL),
    .PHASE_DIRECTION (PHASE_DIRECTION),
    .PHASE_ROTATE    (PHASE_ROTATE),
    .LOAD_PHASE_N    (LOAD_PHASE_N),
    .BUSY            (BUSY),
    .DONE            (DONE),
    .ERR             (ERR),
    .PHASE_POS       (PHASE_POS)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pushes the hand-computed outcome, then presents the request until accepted.
  task automatic issue(input logic [1:0] ch, input logic dir, input logic [7:0] steps,
                       input logic abs_m, input int lat, input logic err,
                       input logic [63:0] mask, input int load, input int sel,
                       input logic [7:0] new_pos);
    exp_t e;
    int   b;
    if (ch < 2'(NO)) exp_pos[ch] = new_pos;
    e.lat    = lat;
    e.err    = err;
    e.dir    = dir;
    e.sel_oh = 3'b001 << ch;
    e.mask   = mask;
    e.load   = load;
    e.sel    = sel;
    e.pos    = {exp_pos[2], exp_pos[1], exp_pos[0]};
    exp_q.push_back(e);
    n_issued++;
    REQ_CH    = ch;
    REQ_DIR   = abs_m ? ~dir : dir;
    REQ_STEPS = steps;
`ifdef PLL_PHASE_STEP_ABS_EN
    REQ_ABS   = abs_m;
`endif
    REQ_VALID = 1'b1;
    b = 0;
    while (!REQ_READY && b < 100) begin
      @(posedge CLK); #1;
      b++;
    end
    if (b >= 100) check("ready_timeout", 64'(REQ_READY), 64'd1);
    @(posedge CLK); #1;
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_done();
    int b = 0;
    while (n_done < n_issued && b < 300) begin
      @(posedge CLK);
      b++;
    end
    #1;
    check("done_timeout", 64'(n_done), 64'(n_issued));
  endtask

  // Monitor: gathers pin activity per transaction and scores it on DONE.
  initial begin
    int          acc_cyc;
    int          r;
    bit          in_txn;
    logic [63:0] rot_mask;
    int          load_cnt;
    int          sel_cnt;
    bit          sel_bad;
    exp_t        cur;
    exp_t        e;
    in_txn = 0; acc_cyc = 0; rot_mask = '0; load_cnt = 0; sel_cnt = 0; sel_bad = 0;
    @(posedge RESET_N);
    forever begin
      @(negedge CLK);
      if (REQ_VALID && REQ_READY) begin
        acc_cyc  = cyc;
        in_txn   = 1;
        rot_mask = '0;
        load_cnt = 0;
        sel_cnt  = 0;
        sel_bad  = 0;
        if (exp_q.size() > 0) cur = exp_q[0];
      end else if (in_txn) begin
        r = cyc - acc_cyc;
        if (PHASE_ROTATE && r < 64) rot_mask[r] = 1'b1;
        if (!LOAD_PHASE_N) load_cnt++;
        if (PHASE_OUT_SEL != 3'b000) begin
          sel_cnt++;
          if (PHASE_OUT_SEL != cur.sel_oh || PHASE_DIRECTION != cur.dir) sel_bad = 1;
        end
      end
      if (DONE) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("done_latency", 64'(cyc - acc_cyc), 64'(e.lat));
          check("done_err",     64'(ERR), 64'(e.err));
          check("positions",    64'(PHASE_POS), 64'(e.pos));
          check("rotate_cycles", rot_mask, e.mask);
          check("load_cycles",  64'(load_cnt), 64'(e.load));
          check("sel_cycles",   64'(sel_cnt), 64'(e.sel));
          check("sel_dir_stable", 64'(sel_bad), 64'd0);
          check("pll_idle_at_done",
                64'({PHASE_OUT_SEL, PHASE_DIRECTION, PHASE_ROTATE, LOAD_PHASE_N, BUSY}),
                64'({3'b000, 1'b0, 1'b0, 1'b1, 1'b0}));
        end
        in_txn = 0;
        n_done++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NO; i++) exp_pos[i] = 8'd0;
    RESET_N   = 1'b0;
    PLL_LOCK  = 1'b1;
    REQ_VALID = 1'b0;
    REQ_CH    = 2'd0;
    REQ_DIR   = 1'b0;
    REQ_STEPS = 8'd0;
`ifdef PLL_PHASE_STEP_ABS_EN
    REQ_ABS   = 1'b0;
`endif
    repeat (3) @(posedge CLK);
    #1;
    check("rst_sel",    64'(PHASE_OUT_SEL), 64'd0);
    check("rst_pins",   64'({PHASE_DIRECTION, PHASE_ROTATE, LOAD_PHASE_N}), 64'(3'b001));
    check("rst_status", 64'({BUSY, DONE, ERR}), 64'd0);
    check("rst_pos",    64'(PHASE_POS), 64'd0);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    check("ready_idle", 64'(REQ_READY), 64'd1);

    // ch1 advance 3: rotate at rel 2-3, 6-7, 10-11; load at 14; done at 31
    issue(2'd1, 1'b1, 8'd3, 1'b0, 31, 1'b0, 64'hCCC, 1, 14, 8'd3);
    check("busy_running", 64'(BUSY), 64'd1);
    wait_done();

    // ch0 retard from 0 wraps to 31, then advance wraps back to 0
    issue(2'd0, 1'b0, 8'd1, 1'b0, 23, 1'b0, 64'hC, 1, 6, 8'd31);
    wait_done();
    issue(2'd0, 1'b1, 8'd1, 1'b0, 23, 1'b0, 64'hC, 1, 6, 8'd0);
    wait_done();

    // ch2 advance 4 with lock lost in the second rotate-high cycle
    issue(2'd2, 1'b1, 8'd4, 1'b0, 7, 1'b1, 64'h4C, 0, 6, 8'd1);
    repeat (5) @(posedge CLK);
    #1;
    PLL_LOCK = 1'b0;
    wait_done();
    check("ready_no_lock", 64'(REQ_READY), 64'd0);
    check("err_sticky_lock", 64'(ERR), 64'd1);
    PLL_LOCK = 1'b1;
    #1;
    check("ready_lock_back", 64'(REQ_READY), 64'd1);

    // zero steps: setup, load, settle only; clears the previous error
    issue(2'd0, 1'b1, 8'd0, 1'b0, 19, 1'b0, 64'h0, 1, 2, 8'd0);
    check("err_cleared", 64'(ERR), 64'd0);
    wait_done();

    // out-of-range channel: done+err one cycle after acceptance, no pin activity
    issue(2'd3, 1'b1, 8'd5, 1'b0, 1, 1'b1, 64'h0, 0, 0, 8'd0);
    wait_done();
    repeat (4) @(posedge CLK);
    #1;
    check("err_sticky_badch", 64'(ERR), 64'd1);

    // ch1 retard 2 from 3 to 1; accepted request clears error
    issue(2'd1, 1'b0, 8'd2, 1'b0, 27, 1'b0, 64'hCC, 1, 10, 8'd1);
    check("err_cleared2", 64'(ERR), 64'd0);
    wait_done();

`ifdef PLL_PHASE_STEP_ABS_EN
    // ch2 from 1 to 2, then absolute 30 (retard 4) and absolute 14 (advance 16)
    issue(2'd2, 1'b1, 8'd1, 1'b0, 23, 1'b0, 64'hC, 1, 6, 8'd2);
    wait_done();
    issue(2'd2, 1'b0, 8'd30, 1'b1, 36, 1'b0, 64'h19998, 1, 18, 8'd30);
    wait_done();
    issue(2'd2, 1'b1, 8'd14, 1'b1, 84, 1'b0, 64'h9999999999999998, 1, 66, 8'd14);
    wait_done();
    issue(2'd2, 1'b1, 8'd40, 1'b1, 1, 1'b1, 64'h0, 0, 0, 8'd14);
    wait_done();
`endif

    repeat (3) @(posedge CLK);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
